// File: rtl/laserdistance_pkg.sv
// Shared definitions for the laser-distance BCD display: FSM encoding,
// distance limit and active-low seven-segment patterns ({g,f,e,d,c,b,a}).
package laserdistance_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [15:0] MAX_DIST    = 16'd9999;
  localparam int          CONV_CYCLES = 16;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD-digit to active-low seven-segment decoder with blanking.
// Non-decimal nibbles decode to blank.
module seg7_decode
  import laserdistance_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/distance_bcd_display.sv
// Converts a saturated 16-bit distance count to four BCD digits by double
// dabble and multiplexes them onto a four-digit common-anode display.
module distance_bcd_display
  import laserdistance_pkg::*;
#(
  parameter int REFRESH_BITS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] din,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd,
  output logic        ovf,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  state_t state, next_state;

  logic [4:0]              iter;
  logic                    ovf_pending;
  logic [15:0]             shift_reg;
  logic [15:0]             acc;
  logic [15:0]             acc_adj;
  logic [REFRESH_BITS-1:0] refresh;
  logic [1:0]              digit_idx;
  logic [3:0]              sel_digit;
  logic                    sel_blank;

  function automatic logic [15:0] sat_dist(input logic [15:0] value);
    return (value > MAX_DIST) ? MAX_DIST : value;
  endfunction

  function automatic logic [15:0] dabble_adjust(input logic [15:0] value);
    logic [15:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*4 +: 4] = (value[i*4 +: 4] >= 4'd5) ? value[i*4 +: 4] + 4'd3
                                                : value[i*4 +: 4];
    end
    return res;
  endfunction

  // FSM state register and next-state logic
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = ST_CONV;
      ST_CONV: if (iter == 5'(CONV_CYCLES - 1)) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Control: iteration count, overflow latch, result registers, status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iter        <= '0;
      ovf_pending <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bcd         <= 16'h0000;
      ovf         <= 1'b0;
    end else begin
      // busy trails the state by one edge so it spans the done cycle
      busy <= (state != ST_IDLE);
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          iter        <= '0;
          ovf_pending <= (din > MAX_DIST);
        end
        ST_CONV: iter <= iter + 5'd1;
        ST_DONE: begin
          bcd  <= acc;
          ovf  <= ovf_pending;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Double-dabble datapath: adjust then shift {acc, shift_reg} left
  assign acc_adj = dabble_adjust(acc);

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      shift_reg <= sat_dist(din);
      acc       <= 16'h0000;
    end else if (state == ST_CONV) begin
      acc       <= {acc_adj[14:0], shift_reg[15]};
      shift_reg <= {shift_reg[14:0], 1'b0};
    end
  end

  // Display multiplexing: free-running refresh counter selects the digit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh   <= '0;
      digit_idx <= 2'd0;
    end else begin
      refresh <= refresh + 1'b1;
      if (&refresh) digit_idx <= digit_idx + 2'd1;
    end
  end

  always_comb begin
    sel_digit = bcd[3:0];
    sel_blank = 1'b0;
    an        = 4'b1110;
    case (digit_idx)
      2'd0: begin
        sel_digit = bcd[3:0];
        sel_blank = 1'b0;
        an        = 4'b1110;
      end
      2'd1: begin
        sel_digit = bcd[7:4];
        sel_blank = (bcd[15:4] == 12'h000);
        an        = 4'b1101;
      end
      2'd2: begin
        sel_digit = bcd[11:8];
        sel_blank = (bcd[15:8] == 8'h00);
        an        = 4'b1011;
      end
      2'd3: begin
        sel_digit = bcd[15:12];
        sel_blank = (bcd[15:12] == 4'h0);
        an        = 4'b0111;
      end
      default: ;
    endcase
  end

  seg7_decode u_seg7_decode (
    .digit (sel_digit),
    .blank (sel_blank),
    .seg   (seg)
  );

endmodule

// File: tb/tb_distance_bcd_display.sv
// Randomized self-checking bench for distance_bcd_display against a decimal
// arithmetic reference model of the conversion and display multiplexing.
module tb_distance_bcd_display;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] din;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        ovf;
  logic [6:0]  seg;
  logic [3:0]  an;

  int n_checks = 0;
  int n_errors = 0;
  int edge_cnt;
  int model_val = 0;
  int model_ovf = 0;
  int done_edge = 0;

  distance_bcd_display #(.REFRESH_BITS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .ovf   (ovf),
    .seg   (seg),
    .an    (an)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [6:0] digit_pattern(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int pos);
    int pw;
    pw = (pos == 0) ? 1 : (pos == 1) ? 10 : (pos == 2) ? 100 : 1000;
    if (pos > 0 && v < pw) return 7'h7F;
    return digit_pattern((v / pw) % 10);
  endfunction

  task automatic disp_check(input int cycles);
    int pos;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      pos = (edge_cnt / 4) % 4;
      chk("an", 32'(an), 32'(~(4'b0001 << pos) & 4'hF));
      chk("seg", 32'(seg), 32'(exp_seg(model_val, pos)));
    end
  endtask

  task automatic run_conv(input logic [15:0] d, input bit tail);
    int lat;
    int prev_v;
    prev_v = model_val;
    lat = -1;
    @(negedge clk);
    din = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 1) chk("busy_rise", 32'(busy), 32'd1);
      if (n == 16) chk("bcd_hold", 32'(bcd), 32'(to_bcd(prev_v)));
      if (done) begin
        lat = n;
        break;
      end
    end
    done_edge = edge_cnt;
    model_val = (int'(d) > 9999) ? 9999 : int'(d);
    model_ovf = (int'(d) > 9999) ? 1 : 0;
    chk("latency", 32'(lat), 32'd17);
    chk("bcd", 32'(bcd), 32'(to_bcd(model_val)));
    chk("ovf", 32'(ovf), 32'(model_ovf));
    chk("busy_at_done", 32'(busy), 32'd1);
    if (tail) begin
      @(posedge clk); #1;
      chk("done_width", 32'(done), 32'd0);
      chk("busy_fall", 32'(busy), 32'd0);
      chk("bcd_keep", 32'(bcd), 32'(to_bcd(model_val)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dones;
    int t1;
    int v;
    reset = 1'b1;
    start = 1'b0;
    din   = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_an", 32'(an), 32'hE);
    chk("rst_seg", 32'(seg), 32'h40);
    @(negedge clk);
    reset = 1'b0;

    run_conv(16'd1234, 1'b1);
    disp_check(16);

    run_conv(16'd0, 1'b1);
    disp_check(16);

    run_conv(16'd10000, 1'b1);
    run_conv(16'd42, 1'b1);
    disp_check(16);

    // second start 5 cycles into a conversion must be dropped
    @(negedge clk);
    din = 16'd500;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    din = 16'd777;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (int n = 0; n < 35; n++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    model_val = 500;
    model_ovf = 0;
    chk("ignored_start_dones", 32'(dones), 32'd1);
    chk("ignored_start_bcd", 32'(bcd), 32'h0500);
    chk("ignored_start_busy", 32'(busy), 32'd0);

    // reset aborting a conversion
    @(posedge clk); #1;
    run_conv(16'd0, 1'b1);
    @(negedge clk);
    din = 16'd65535;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_val = 0;
    model_ovf = 0;
    dones = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    chk("abort_bcd", 32'(bcd), 32'h0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    run_conv(16'd9, 1'b1);
    disp_check(16);

    // back-to-back acceptance right after done
    run_conv(16'd4321, 1'b0);
    t1 = done_edge;
    run_conv(16'd1, 1'b1);
    chk("b2b_gap", 32'(done_edge - t1), 32'd18);

    for (int it = 0; it < 14; it++) begin
      case ($urandom_range(0, 3))
        0: v = int'($urandom_range(0, 99));
        1: v = int'($urandom_range(0, 9999));
        2: v = int'($urandom_range(0, 65535));
        default: v = int'($urandom_range(9998, 10001));
      endcase
      run_conv(16'(v), 1'b1);
      disp_check(16);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/distance_bcd_display.md
DISTANCE_BCD_DISPLAY -- requirements
Module: distance_bcd_display

Interface
REQ-001 Parameter REFRESH_BITS, 16, width of the digit-multiplex refresh counter; the active digit advances when the counter wraps.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle strobe: din holds a new distance count.
REQ-005 din  input  16  unsigned distance count from the laser distance FSMD.
REQ-006 busy  output  1  high whenever the FSM is not in IDLE.
REQ-007 done  output  1  one-cycle pulse: bcd/ovf updated.
REQ-008 bcd  output  16  four packed BCD digits; [3:0] is the ones digit.
REQ-009 ovf  output  1  the last converted din exceeded 9999.
REQ-010 seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-011 an  output  4  active-low one-hot digit enables; an[0] is the ones digit.

Function
REQ-012 FSM states SHALL be IDLE, CONV and DONE; no other states are reachable.
REQ-013 In IDLE, start=1 SHALL capture min(din, 9999) into a 16-bit binary shift register, clear the 16-bit BCD accumulator and the 5-bit iteration counter, latch ovf_pending=(din>9999), and go to CONV.
REQ-014 In CONV, each cycle SHALL add 3 to every accumulator digit that is >=5, then shift {accumulator, shift register} left by 1 (double dabble).
REQ-015 CONV SHALL last exactly 16 cycles, then go to DONE.
REQ-016 DONE SHALL last one cycle: load bcd from the accumulator, load ovf from ovf_pending, assert done, and return to IDLE.
REQ-017 Latency: if start is sampled at edge k, busy SHALL be high from edge k+1, and bcd, ovf and done SHALL update at edge k+17.
REQ-018 done SHALL be high for exactly one cycle.
REQ-019 busy SHALL fall at edge k+18.
REQ-020 start while busy=1 (CONV or DONE) SHALL be ignored, with no queuing.
REQ-021 A start in the cycle after DONE SHALL be accepted normally.
REQ-022 bcd and ovf SHALL hold their values between done pulses.
REQ-023 The refresh counter SHALL free-run every cycle.
REQ-024 On each refresh-counter wrap, the digit index SHALL advance 0->1->2->3->0.
REQ-025 an SHALL be the active-low one-hot of the digit index.
REQ-026 seg SHALL be the active-low decode of the selected bcd digit.
REQ-027 Leading-zero blanking: digits 3..1 SHALL show blank (7'b1111111) when they and all higher digits are zero; digit 0 SHALL always be displayed.
REQ-028 BCD nibbles greater than 9 cannot occur; the decoder SHALL nonetheless map them to blank.

Reset
REQ-029 Reset SHALL force: state=IDLE, busy=0, done=0, bcd=16'h0000, ovf=0, refresh counter=0, digit index=0.
REQ-030 Reset SHALL force an=4'b1110 and seg=7'b1000000 (shows "0").
REQ-031 Reset asserted mid-CONV SHALL abort the conversion; no done pulse SHALL follow, and bcd SHALL remain 0.

Structure
REQ-032 A shared package laserdistance_pkg SHALL hold: FSM state encoding, MAX_DIST=9999, SEG_BLANK, and the 0-9 segment constants.
REQ-033 Segment decoding SHALL live in one combinational sub-module, seg7_decode (4-bit digit plus blank flag in, 7-bit seg out).
REQ-034 Conversion datapath and FSM SHALL remain in distance_bcd_display.

Verification
REQ-035 din=1234, start at edge k -> done at k+17, bcd=16'h1234, ovf=0, busy low at k+18.
REQ-036 din=0 -> bcd=16'h0000; with REFRESH_BITS=2, an cycles 1110,1101,1011,0111 every 4 cycles; seg=1000000 on digit 0 and 1111111 on the others.
REQ-037 din=10000 -> bcd=16'h9999, ovf=1; then din=42 -> bcd=16'h0042, ovf=0; digits 3 and 2 blank.
REQ-038 din=500, then start pulsed again 5 cycles later with din=777 -> exactly one done, bcd=16'h0500.
REQ-039 din=65535, reset asserted 8 cycles after start -> busy=0 immediately, no done, bcd=0, next start with din=9 -> bcd=16'h0009.
REQ-040 Back-to-back: start with din=1 is accepted the cycle after the previous done -> second done exactly 18 cycles after the first.
